// File: rtl/inst_fetch_unit.sv
// Instruction fetch responder: builds big-endian 32-bit words from a byte-wide store in four read beats.
// Optional IMEM_RANGE_CHECK_EN: misaligned or out-of-range requests return an error response instead of a fetch.
module inst_fetch_unit #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_address,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_instruction,
    output logic [31:0]          rsp_address,
    output logic                 rsp_error,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [7:0]           load_byte
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FAULT,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_beat;
    logic [31:0]          r_instr;
    logic [31:0]          r_addr;
    logic                 r_err;
    logic [7:0]           r_mem [MEM_BYTES];
    logic                 w_accept;
    logic                 w_fault;
    logic [ADDR_BITS-1:0] w_rd_idx;

    assign w_accept = req_valid && (r_state == S_IDLE);
    // Index arithmetic is ADDR_BITS wide, so a fetch near the top of the store wraps to byte 0.
    assign w_rd_idx = r_addr[ADDR_BITS-1:0] + ADDR_BITS'(r_beat);

`ifdef IMEM_RANGE_CHECK_EN
    assign w_fault = (req_address[1:0] != 2'b00) || (req_address >= 32'(MEM_BYTES));
`else
    assign w_fault = 1'b0;
`endif

    // NOTE: the store has no reset; clearing every byte would force it into flops instead of RAM.
    always_ff @(posedge clock) begin
        if (load_en) begin
            r_mem[load_address] <= load_byte;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (req_valid) w_next = w_fault ? S_FAULT : S_READ;
            S_READ:  if (r_beat == 2'd3) w_next = S_RESP;
            S_FAULT: w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking reads of r_mem see the pre-edge byte, giving read-before-write on a same-cycle load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_beat  <= 2'd0;
            r_instr <= 32'd0;
            r_addr  <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_beat  <= 2'd0;
            r_instr <= 32'd0;
            r_addr  <= req_address;
            r_err   <= w_fault;
        end else if (r_state == S_READ) begin
            r_instr <= {r_instr[23:0], r_mem[w_rd_idx]};
            r_beat  <= r_beat + 2'd1;
        end
    end

    assign req_ready       = (r_state == S_IDLE);
    assign rsp_valid       = (r_state == S_RESP);
    assign rsp_instruction = r_instr;
    assign rsp_address     = r_addr;
    assign rsp_error       = r_err;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
// Honours IMEM_RANGE_CHECK_EN when the design is built with it.
module tb_inst_fetch_unit;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_BITS = 6;

    logic                 clock        = 1'b0;
    logic                 reset_n      = 1'b0;
    logic                 req_valid    = 1'b0;
    logic [31:0]          req_address  = 32'd0;
    logic                 rsp_ready    = 1'b0;
    logic                 load_en      = 1'b0;
    logic [ADDR_BITS-1:0] load_address = '0;
    logic [7:0]           load_byte    = 8'd0;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [31:0]          rsp_instruction;
    logic [31:0]          rsp_address;
    logic                 rsp_error;

    int          total   = 0;
    int          bad     = 0;
    int unsigned cyc     = 0;
    int unsigned acc_cyc = 0;

    inst_fetch_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_BITS(ADDR_BITS)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_instruction (rsp_instruction),
        .rsp_address     (rsp_address),
        .rsp_error       (rsp_error),
        .load_en         (load_en),
        .load_address    (load_address),
        .load_byte       (load_byte)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  m_mem [MEM_BYTES];
    logic [7:0]  m_b [4];
    bit          m_busy  = 1'b0;
    bit          m_rv    = 1'b0;
    bit          m_fault = 1'b0;
    bit          m_err   = 1'b0;
    int          m_step  = 0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_word  = 32'd0;

    function automatic bit is_fault(input logic [31:0] a);
`ifdef IMEM_RANGE_CHECK_EN
        return (a % 4 != 0) || (a >= MEM_BYTES);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) m_mem[i] = 8'd0;
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                m_busy = 0; m_rv = 0; m_fault = 0; m_err = 0; m_addr = 0; m_word = 0;
            end else if (m_rv) begin
                if (rsp_ready) begin
                    m_rv   = 0;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                m_step = m_step + 1;
                if (m_fault) begin
                    m_rv = 1;
                end else begin
                    m_b[m_step-1] = m_mem[(m_addr + m_step - 1) % MEM_BYTES];
                    if (m_step == 4) begin
                        m_word = {m_b[0], m_b[1], m_b[2], m_b[3]};
                        m_rv   = 1;
                    end
                end
            end else if (req_valid) begin
                m_busy  = 1;
                m_step  = 0;
                m_addr  = req_address;
                m_fault = is_fault(req_address);
                m_err   = m_fault;
                m_word  = 32'd0;
            end
            // Store update comes after the byte capture: same-edge loads are not seen by the fetch.
            if (load_en) m_mem[load_address] = load_byte;
        end
    end

    initial begin
        forever begin
            @(negedge reset_n);
            m_busy = 0; m_rv = 0; m_fault = 0; m_err = 0; m_addr = 0; m_word = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("cmp_req_ready", req_ready, !m_busy);
                check("cmp_rsp_valid", rsp_valid, m_rv);
                if (m_rv) begin
                    check("cmp_rsp_instruction", rsp_instruction, m_word);
                    check("cmp_rsp_address", rsp_address, m_addr);
                    check("cmp_rsp_error", rsp_error, m_err);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_b(input int idx, input logic [7:0] v);
        @(negedge clock);
        load_en      = 1'b1;
        load_address = ADDR_BITS'(idx);
        load_byte    = v;
        @(posedge clock);
        #1 load_en = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid   = 1'b1;
        req_address = a;
        @(negedge clock);
        req_valid   = 1'b0;
        req_address = $urandom;
        acc_cyc     = cyc;
    endtask

    task automatic wait_rsp(input int stall, output int lat, output logic [31:0] w,
                            output logic [31:0] a, output logic e);
        rsp_ready = (stall == 0);
        while (!rsp_valid && (cyc - acc_cyc) < 30) @(negedge clock);
        check("rsp_arrives", rsp_valid, 1);
        lat = int'(cyc - acc_cyc);
        w   = rsp_instruction;
        a   = rsp_address;
        e   = rsp_error;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_hold_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic        e;
        int          lat;
        int unsigned prev_acc;
        logic [31:0] step_exp [4];

        step_exp = '{32'h20080005, 32'hDEADBEEF, 32'h0102FF04, 32'hCAFEBABE};
        prev_acc = 0;

        #12;
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_instruction", rsp_instruction, 0);
        check("reset_rsp_address", rsp_address, 0);
        check("reset_rsp_error", rsp_error, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < MEM_BYTES; i++) load_b(i, 8'($urandom));
        load_b(0, 8'h20);  load_b(1, 8'h08);  load_b(2, 8'h00);  load_b(3, 8'h05);
        load_b(4, 8'hDE);  load_b(5, 8'hAD);  load_b(6, 8'hBE);  load_b(7, 8'hEF);
        load_b(8, 8'h01);  load_b(9, 8'h02);  load_b(10, 8'h5A); load_b(11, 8'h04);
        load_b(12, 8'hCA); load_b(13, 8'hFE); load_b(14, 8'hBA); load_b(15, 8'hBE);
        load_b(62, 8'h11); load_b(63, 8'h22);

        // Basic fetch
        start_req(32'h0);
        wait_rsp(0, lat, w, a, e);
        check("basic_word", w, 32'h20080005);
        check("basic_latency", lat, 4);
        check("basic_address", a, 32'h0);
        @(negedge clock);
        check("basic_ready_back", req_ready, 1);

        // Backpressure: ten stalled cycles, then exactly one handshake
        start_req(32'h4);
        wait_rsp(10, lat, w, a, e);
        check("bp_word", w, 32'hDEADBEEF);
        check("bp_address", a, 32'h4);
        @(negedge clock);
        check("bp_single_handshake_valid", rsp_valid, 0);
        check("bp_single_handshake_ready", req_ready, 1);

        // Wrap / fault at the top of the store
        start_req(32'h3E);
        wait_rsp(0, lat, w, a, e);
        check("wrap_address", a, 32'h3E);
`ifdef IMEM_RANGE_CHECK_EN
        check("fault_word", w, 32'h0);
        check("fault_error", e, 1);
        check("fault_latency", lat, 1);
`else
        check("wrap_word", w, 32'h11222008);
        check("wrap_error", e, 0);
        check("wrap_latency", lat, 4);
`endif

        // Write collision on beat 2 (byte 10) of a fetch of 0x8
        start_req(32'h8);
        @(negedge clock);
        @(negedge clock);
        load_en      = 1'b1;
        load_address = ADDR_BITS'(10);
        load_byte    = 8'hFF;
        @(negedge clock);
        load_en      = 1'b0;
        wait_rsp(0, lat, w, a, e);
        check("collision_old_byte", w, 32'h01025A04);
        start_req(32'h8);
        wait_rsp(0, lat, w, a, e);
        check("collision_refetch", w, 32'h0102FF04);

        // Reset during beat 1
        start_req(32'h4);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_req_ready", req_ready, 1);
        check("midreset_rsp_valid", rsp_valid, 0);
        check("midreset_rsp_instruction", rsp_instruction, 0);
        check("midreset_rsp_address", rsp_address, 0);
        check("midreset_rsp_error", rsp_error, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("midreset_no_response", rsp_valid, 0);
        end
        start_req(32'h0);
        wait_rsp(0, lat, w, a, e);
        check("post_reset_word", w, 32'h20080005);

        // PC stepping at peak rate
        for (int i = 0; i < 4; i++) begin
            start_req(32'(i * 4));
            if (i > 0) check("step_spacing", acc_cyc - prev_acc, 6);
            prev_acc = acc_cyc;
            wait_rsp(0, lat, w, a, e);
            check("step_word", w, step_exp[i]);
        end

        // Randomized traffic, loads and backpressure; checked cycle by cycle against the model
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            req_valid    = ($urandom % 3 == 0);
            req_address  = ($urandom % 2 == 1) ? {26'd0, 4'($urandom), 2'b00} : 32'($urandom);
            rsp_ready    = ($urandom % 2 == 1);
            load_en      = ($urandom % 4 == 0);
            load_address = ADDR_BITS'($urandom);
            load_byte    = 8'($urandom);
        end
        @(negedge clock);
        req_valid = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
